nios2_tx_data_fifo: RTL

Parametrised Avalon-MM transmit-data port for the NIOS2 system: CPU writes data words into a DEPTH-entry FIFO, and the block drains them to the TX datapath over a valid/ready stream. It adds several things a plain output register lacks: buffering, flow control, status and sticky error flags, a software flush, and a level-threshold interrupt. It sits between the Avalon interconnect and the TX modulator front end.

---
 rtl/nios2_tx_data_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/nios2_tx_data_fifo.sv
// Avalon-MM transmit-data FIFO: the CPU pushes words, the TX datapath drains them over valid/ready.
// Provides level/status readback, sticky overflow/underrun, software flush and a threshold interrupt.
module nios2_tx_data_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  irq
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LEVEL_W = AW + 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [LEVEL_W-1:0]    level;
    logic [LEVEL_W-1:0]    threshold;
    logic [DATA_WIDTH-1:0] shadow;
    logic                  enable;
    logic                  irq_en;
    logic                  overflow;
    logic                  underrun;

    logic wr;
    logic data_wr;
    logic status_wr;
    logic ctrl_wr;
    logic thr_wr;
    logic flush;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic unused_wdata;

    assign wr        = chipselect & ~write_n;
    assign data_wr   = wr & (address == ADDR_DATA);
    assign status_wr = wr & (address == ADDR_STATUS);
    assign ctrl_wr   = wr & (address == ADDR_CTRL);
    assign thr_wr    = wr & (address == 2'd3);
    assign flush     = ctrl_wr & writedata[1];

    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);

    // Head is driven purely from registered state, never from tx_ready.
    assign tx_valid = enable & ~empty;
    assign tx_data  = empty ? '0 : mem[rd_ptr];

    // A flush wins over both ends of the FIFO in its cycle.
    assign push = data_wr & ~full & ~flush;
    assign pop  = tx_valid & tx_ready & ~flush;

    assign unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            shadow    <= '0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            threshold <= '0;
            overflow  <= 1'b0;
            underrun  <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push & ~pop)      level <= level + LEVEL_W'(1);
                else if (pop & ~push) level <= level - LEVEL_W'(1);
            end

            if (push) shadow <= writedata[DATA_WIDTH-1:0];

            if (ctrl_wr) begin
                enable <= writedata[0];
                irq_en <= writedata[2];
            end
            if (thr_wr) threshold <= writedata[LEVEL_W-1:0];

            // A new error event in the same cycle as a clear is kept.
            if (status_wr & writedata[18])     overflow <= 1'b0;
            if (data_wr & full & ~flush)       overflow <= 1'b1;
            if (status_wr & writedata[19])     underrun <= 1'b0;
            if (enable & empty & tx_ready)     underrun <= 1'b1;

            irq <= irq_en & ((level <= threshold) | overflow);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata[DATA_WIDTH-1:0] = shadow;
            ADDR_STATUS: begin
                readdata[LEVEL_W-1:0] = level;
                readdata[16]          = empty;
                readdata[17]          = full;
                readdata[18]          = overflow;
                readdata[19]          = underrun;
            end
            ADDR_CTRL: begin
                readdata[0] = enable;
                readdata[2] = irq_en;
            end
            default: readdata[LEVEL_W-1:0] = threshold;
        endcase
    end
endmodule
